// File: rtl/down_counter_tff_pkg.sv
// Shared constants and types for the down counter and its up-counter siblings.
// Provides the default width, the widest legal all-ones value and the per-edge action type.
// No logic; imported by the interface and the counter.
package down_counter_tff_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 16;

  // Wrap target for the widest legal counter; narrower counters take the low bits.
  localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

  // What the counter does at the next rising edge.
  typedef enum logic [2:0] {
    ACT_HOLD   = 3'd0,
    ACT_LOAD   = 3'd1,
    ACT_DEC    = 3'd2,
    ACT_WRAP   = 3'd3,
    ACT_RELOAD = 3'd4
  } action_e;

  // All-ones value of a given width, as used for wrap checks.
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned width);
    return ALL_ONES >> (MAX_WIDTH - width);
  endfunction

endpackage

// File: rtl/down_counter_tff_if.sv
// Control and status bundle of one down counter stage.
// The master drives enable/load/din/auto_reload; the counter (slave) drives q/zero/borrow_out/done.
// Cascading connects one stage's borrow_out to the next stage's enable.
interface down_counter_tff_if
  import down_counter_tff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             enable;
  logic             load;
  logic             auto_reload;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             borrow_out;
  logic             done;

  modport master (
    output enable, load, auto_reload, din,
    input  q, zero, borrow_out, done
  );

  modport slave (
    input  enable, load, auto_reload, din,
    output q, zero, borrow_out, done
  );

endinterface

// File: rtl/down_counter_tff_tff.sv
// Toggle flip-flop cell: q inverts on a rising clock edge when t is high.
// Latency: one clock from t to the new q; clear is asynchronous and immediate.
// No backpressure.
module tff (
  output logic q,
  input  logic t,
  input  logic clock,
  input  logic clear
);

  // Toggle state, cleared asynchronously.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/down_counter_tff.sv
// Binary down counter built from tff cells with load, enable, auto-reload and borrow-out.
// Latency: one clock from load/enable to the new q; zero/borrow_out are combinational, done is registered.
// No backpressure; borrow_out feeds the next stage's enable combinationally.
module down_counter_tff
  import down_counter_tff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clock,
  input logic                clear,
  down_counter_tff_if.slave  bus
);

  logic [WIDTH-1:0] q_cur;
  logic [WIDTH-1:0] t_cnt;
  logic [WIDTH-1:0] t_ld;
  logic [WIDTH-1:0] t;
  logic             cnt_zero;
  logic             done_r;
  logic             done_next;
  action_e          action;

  assign cnt_zero = (q_cur == '0);

  // Decide what the next edge does; load beats enable, zero picks wrap or reload.
  always_comb begin
    action = ACT_HOLD;
    if (bus.load) begin
      action = ACT_LOAD;
    end else if (bus.enable) begin
      if (!cnt_zero) begin
        action = ACT_DEC;
      end else if (bus.auto_reload) begin
        action = ACT_RELOAD;
      end else begin
        action = ACT_WRAP;
      end
    end
  end

  // Count path: a bit toggles when every lower bit is zero (borrow ripples up).
  // At q == 0 every bit toggles, which is exactly the wrap to all-ones.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
        assign t_cnt[i] = bus.enable;
      end else begin : g_upper
        assign t_cnt[i] = bus.enable & ~|q_cur[i-1:0];
      end

      tff u_tff (
        .q     (q_cur[i]),
        .t     (t[i]),
        .clock (clock),
        .clear (clear)
      );
    end
  endgenerate

  // Load path: toggle exactly the bits that differ from din.
  assign t_ld = q_cur ^ bus.din;

  // Per-bit mux between load/reload and count toggles.
  always_comb begin
    t = '0;
    case (action)
      ACT_LOAD, ACT_RELOAD: t = t_ld;
      ACT_DEC, ACT_WRAP:    t = t_cnt;
      default:              t = '0;
    endcase
  end

  // Only a counted 1 -> 0 step raises done; loading zero does not.
  assign done_next = (action == ACT_DEC) && (q_cur == WIDTH'(1));

  // One-cycle done pulse, dropped at once by clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_next;
    end
  end

  assign bus.q          = q_cur;
  assign bus.zero       = cnt_zero;
  assign bus.borrow_out = bus.enable & cnt_zero;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_down_counter_tff.sv
module tb_down_counter_tff;

  localparam int W = 4;

  logic clock = 1'b0;
  logic clear = 1'b0;

  down_counter_tff_if #(.WIDTH(W)) bus ();
  down_counter_tff_if #(.WIDTH(W)) bus_hi ();

  down_counter_tff #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  down_counter_tff #(.WIDTH(W)) dut_hi (
    .clock (clock),
    .clear (clear),
    .bus   (bus_hi.slave)
  );

  // high stage counts when the low stage borrows
  assign bus_hi.enable = bus.borrow_out;

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // reference model: count value and done flag of the low stage
  int m_q = 0;
  bit m_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_q = 0;
      m_done = 1'b0;
    end else if (bus.load) begin
      m_q = int'(bus.din);
      m_done = 1'b0;
    end else if (bus.enable) begin
      if (m_q != 0) begin
        m_done = (m_q == 1);
        m_q = m_q - 1;
      end else begin
        m_done = 1'b0;
        m_q = bus.auto_reload ? int'(bus.din) : (1 << W) - 1;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // compare DUT against the model away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_q", int'(bus.q), m_q);
      check("model_zero", int'(bus.zero), int'(m_q == 0));
      check("model_borrow", int'(bus.borrow_out), int'(bus.enable && m_q == 0));
      check("model_done", int'(bus.done), int'(m_done));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int exp_cd[4];
    int exp_dn[4];
    int exp_ar[5];
    int exp_ad[5];

    bus.enable = 1'b0;
    bus.load = 1'b0;
    bus.auto_reload = 1'b0;
    bus.din = '0;
    bus_hi.load = 1'b0;
    bus_hi.auto_reload = 1'b0;
    bus_hi.din = '0;

    // reset state
    #1 clear = 1'b1;
    #2;
    check("reset_q", int'(bus.q), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_zero", int'(bus.zero), 1);
    check("reset_borrow", int'(bus.borrow_out), 0);
    #5 clear = 1'b0;
    chk_en = 1'b1;

    // count-down from load 3
    bus.din = 4'd3;
    bus.load = 1'b1;
    tick();
    check("cd_load_q", int'(bus.q), 3);
    bus.load = 1'b0;
    bus.enable = 1'b1;
    exp_cd = '{2, 1, 0, 15};
    exp_dn = '{0, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      check("cd_borrow_pre", int'(bus.borrow_out), int'(k == 3));
      tick();
      check("cd_q", int'(bus.q), exp_cd[k]);
      check("cd_done", int'(bus.done), exp_dn[k]);
    end
    bus.enable = 1'b0;

    // asynchronous clear mid-cycle at q=9
    bus.din = 4'd9;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("clr_pre_q", int'(bus.q), 9);
    #2 clear = 1'b1;
    #1;
    check("clr_q", int'(bus.q), 0);
    check("clr_done", int'(bus.done), 0);
    check("clr_zero", int'(bus.zero), 1);
    clear = 1'b0;

    // auto-reload din=2
    bus.auto_reload = 1'b1;
    bus.din = 4'd2;
    bus.load = 1'b1;
    tick();
    check("ar_load_q", int'(bus.q), 2);
    bus.load = 1'b0;
    bus.enable = 1'b1;
    exp_ar = '{1, 0, 2, 1, 0};
    exp_ad = '{0, 1, 0, 0, 1};
    for (int k = 0; k < 5; k++) begin
      tick();
      check("ar_q", int'(bus.q), exp_ar[k]);
      check("ar_done", int'(bus.done), exp_ad[k]);
    end

    // auto-reload with din=0 sticks at zero with borrow high
    bus.din = 4'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ar0_q", int'(bus.q), 0);
      check("ar0_borrow", int'(bus.borrow_out), 1);
    end
    bus.enable = 1'b0;
    bus.auto_reload = 1'b0;

    // load has priority over enable
    bus.din = 4'd7;
    bus.load = 1'b1;
    tick();
    bus.din = 4'd12;
    bus.enable = 1'b1;
    tick();
    check("prio_q", int'(bus.q), 12);
    check("prio_done", int'(bus.done), 0);
    bus.load = 1'b0;
    bus.enable = 1'b0;

    // hold at 5, then load zero from one
    bus.din = 4'd5;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_q", int'(bus.q), 5);
    end
    bus.din = 4'd1;
    bus.load = 1'b1;
    tick();
    bus.din = 4'd0;
    tick();
    check("load0_q", int'(bus.q), 0);
    check("load0_done", int'(bus.done), 0);
    bus.load = 1'b0;

    // cascade: high=1, low=0 -> 16, then count to 15 and 14
    bus.din = 4'd0;
    bus.load = 1'b1;
    bus_hi.din = 4'd1;
    bus_hi.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus_hi.load = 1'b0;
    check("casc_init", int'({bus_hi.q, bus.q}), 16);
    bus.enable = 1'b1;
    #1;
    check("casc_borrow", int'(bus.borrow_out), 1);
    tick();
    check("casc_lo", int'(bus.q), 15);
    check("casc_hi", int'(bus_hi.q), 0);
    check("casc_15", int'({bus_hi.q, bus.q}), 15);
    tick();
    check("casc_14", int'({bus_hi.q, bus.q}), 14);
    bus.enable = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
